// File: rtl/bypass_pkg.sv
// Shared types and constants for the operand-forwarding network.
// History entries are laid out with the default core widths below.
package bypass_pkg;

  localparam int BYPASS_DATA_W = 32;
  localparam int BYPASS_ADDR_W = 5;

  localparam int SEL_RF   = 0;
  localparam int SEL_EX   = 1;
  localparam int SEL_STG0 = 2;

  // Select must encode rf, ex and every history stage.
  function automatic int sel_w(input int depth);
    return $clog2(depth + 2);
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [BYPASS_ADDR_W-1:0] rd;
    logic [BYPASS_DATA_W-1:0] data;
    logic                     is_load;
  } hist_entry_t;

endpackage

// File: rtl/bypass_match.sv
// Per-port priority match over the EX candidate and the history stages.
// Candidate 0 is the youngest; a pending candidate stalls instead of forwarding.
module bypass_match
  import bypass_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NCAND  = 3,
  parameter int SEL_W  = 2
) (
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [DATA_W-1:0]       rf_data,
  input  logic [NCAND-1:0]        cand_valid,
  input  logic [NCAND*ADDR_W-1:0] cand_rd,
  input  logic [NCAND*DATA_W-1:0] cand_data,
  input  logic [NCAND-1:0]        cand_pend,
  output logic [DATA_W-1:0]       data,
  output logic [SEL_W-1:0]        sel,
  output logic                    pending
);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    data    = rf_data;
    sel     = SEL_W'(SEL_RF);
    pending = 1'b0;
    for (int i = NCAND - 1; i >= 0; i--) begin
      if (cand_valid[i] && (rd_addr != '0) &&
          (cand_rd[i*ADDR_W +: ADDR_W] == rd_addr)) begin
        data    = cand_pend[i] ? rf_data : cand_data[i*DATA_W +: DATA_W];
        sel     = SEL_W'(i + 1);
        pending = cand_pend[i];
      end
    end
  end

endmodule

// File: rtl/bypass_net.sv
// Operand-forwarding network: owns the in-flight write history and
// resolves each read port against it, newest producer first.
module bypass_net
  import bypass_pkg::*;
#(
  parameter int DATA_W = BYPASS_DATA_W,
  parameter int ADDR_W = BYPASS_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 2,
  localparam int SEL_W = sel_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  input  logic [ADDR_W-1:0]        ex_rd,
  input  logic [DATA_W-1:0]        ex_data,
  input  logic                     ex_is_load,
  input  logic [DATA_W-1:0]        mem_ld_data,
  input  logic                     hold,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rf_data,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic [NUM_RD*SEL_W-1:0]  fwd_sel,
  output logic                     hazard
);

  localparam int NCAND = DEPTH + 1;

  hist_entry_t stg [DEPTH];

  logic [NCAND-1:0]        cand_valid;
  logic [NCAND*ADDR_W-1:0] cand_rd;
  logic [NCAND*DATA_W-1:0] cand_data;
  logic [NCAND-1:0]        cand_pend;
  logic [NUM_RD-1:0]       port_pend;

  // A load leaving stg[0] picks up its memory data and stops being a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else begin
      if (!hold) begin
        stg[0].valid   <= ex_valid;
        stg[0].rd      <= ex_rd;
        stg[0].data    <= ex_data;
        stg[0].is_load <= ex_is_load;
        for (int k = 1; k < DEPTH; k++) begin
          stg[k] <= stg[k-1];
          if (k == 1 && stg[0].is_load) begin
            stg[k].data    <= mem_ld_data;
            stg[k].is_load <= 1'b0;
          end
        end
      end
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) stg[k].valid <= 1'b0;
      end
    end
  end

  always_comb begin
    cand_valid                = '0;
    cand_rd                   = '0;
    cand_data                 = '0;
    cand_pend                 = '0;
    cand_valid[0]             = ex_valid;
    cand_rd[0 +: ADDR_W]      = ex_rd;
    cand_data[0 +: DATA_W]    = ex_data;
    cand_pend[0]              = ex_is_load;
    for (int k = 0; k < DEPTH; k++) begin
      cand_valid[k+1]               = stg[k].valid;
      cand_rd[(k+1)*ADDR_W +: ADDR_W] = stg[k].rd;
      cand_data[(k+1)*DATA_W +: DATA_W] =
        (k == 0 && stg[k].is_load) ? mem_ld_data : stg[k].data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    bypass_match #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NCAND (NCAND),
      .SEL_W (SEL_W)
    ) u_match (
      .rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
      .rf_data   (rf_data[p*DATA_W +: DATA_W]),
      .cand_valid(cand_valid),
      .cand_rd   (cand_rd),
      .cand_data (cand_data),
      .cand_pend (cand_pend),
      .data      (fwd_data[p*DATA_W +: DATA_W]),
      .sel       (fwd_sel[p*SEL_W +: SEL_W]),
      .pending   (port_pend[p])
    );
  end

  assign hazard = |port_pend;

endmodule

// File: tb/tb_bypass_net.sv
// Directed and randomized checks of bypass_net against a queue-based
// model of the in-flight write history.
module tb_bypass_net;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int DEP = 2;
  localparam int SW  = $clog2(DEP + 2);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid;
  logic [AW-1:0]     ex_rd;
  logic [DW-1:0]     ex_data;
  logic              ex_is_load;
  logic [DW-1:0]     mem_ld_data;
  logic              hold;
  logic              flush;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rf_data;
  logic [NRD*DW-1:0] fwd_data;
  logic [NRD*SW-1:0] fwd_sel;
  logic              hazard;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          valid;
    bit [AW-1:0] rd;
    bit [DW-1:0] data;
    bit          is_load;
  } ent_t;

  ent_t hist[$];

  bypass_net #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .ex_is_load (ex_is_load),
    .mem_ld_data(mem_ld_data),
    .hold       (hold),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rf_data    (rf_data),
    .fwd_data   (fwd_data),
    .fwd_sel    (fwd_sel),
    .hazard     (hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest producer wins: EX first, then history from youngest to oldest.
  task automatic resolve(input int p, output logic [DW-1:0] d, output logic [SW-1:0] s,
                         output logic pend);
    logic [AW-1:0] a;
    a    = rd_addr[p*AW +: AW];
    d    = rf_data[p*DW +: DW];
    s    = '0;
    pend = 1'b0;
    if (a == 0) return;
    if (ex_valid && ex_rd == a) begin
      s    = SW'(1);
      pend = ex_is_load;
      if (!ex_is_load) d = ex_data;
      return;
    end
    foreach (hist[k]) begin
      if (hist[k].valid && hist[k].rd == a) begin
        s = SW'(k + 2);
        d = (k == 0 && hist[k].is_load) ? mem_ld_data : hist[k].data;
        return;
      end
    end
  endtask

  task automatic modelEdge();
    ent_t e;
    if (!hold) begin
      if (hist.size() > 0 && hist[0].is_load) begin
        hist[0].data    = mem_ld_data;
        hist[0].is_load = 1'b0;
      end
      e.valid   = ex_valid;
      e.rd      = ex_rd;
      e.data    = ex_data;
      e.is_load = ex_is_load;
      hist.push_front(e);
      while (hist.size() > DEP) void'(hist.pop_back());
    end
    if (flush) foreach (hist[k]) hist[k].valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                               input logic ld, input logic [DW-1:0] mld, input logic h,
                               input logic f, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    ex_valid    = v;
    ex_rd       = rd;
    ex_data     = d;
    ex_is_load  = ld;
    mem_ld_data = mld;
    hold        = h;
    flush       = f;
    rd_addr     = {a1, a0};
    rf_data     = {r1, r0};
    #2;
  endtask

  task automatic checkOutput(input string tag);
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic          ph;
    logic          eh;
    eh = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      resolve(p, ed, es, ph);
      eh |= ph;
      chk($sformatf("%s.data%0d", tag, p), 64'(fwd_data[p*DW +: DW]), 64'(ed));
      chk($sformatf("%s.sel%0d", tag, p), 64'(fwd_sel[p*SW +: SW]), 64'(es));
    end
    chk($sformatf("%s.hazard", tag), 64'(hazard), 64'(eh));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hist.delete();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 6, 32'h11, 32'h22);
    checkOutput("reset");
    chk("reset.data0", 64'(fwd_data[0 +: DW]), 64'h11);
    chk("reset.sel0", 64'(fwd_sel[0 +: SW]), 64'd0);
    tick();

    // EX forward, then stg0, stg1, aged out
    applyStimulus(1, 5, 32'hAA, 0, 0, 0, 0, 5, 0, 32'h11, 32'h0);
    checkOutput("ex");
    chk("ex.plan", 64'(fwd_data[0 +: DW]), 64'hAA);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0, 32'h11, 32'h0);
    checkOutput("stg0");
    chk("stg0.plan", 64'(fwd_sel[0 +: SW]), 64'd2);
    tick();
    checkOutput("stg1");
    chk("stg1.plan", 64'(fwd_sel[0 +: SW]), 64'd3);
    tick();
    checkOutput("aged");
    chk("aged.plan", 64'(fwd_data[0 +: DW]), 64'h11);

    // consecutive writes to r5: younger wins
    applyStimulus(1, 5, 32'h1, 0, 0, 0, 0, 5, 5, 32'h11, 32'h11);
    tick();
    applyStimulus(1, 5, 32'h2, 0, 0, 0, 0, 5, 5, 32'h11, 32'h11);
    checkOutput("dup.ex");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 5, 32'h11, 32'h11);
    checkOutput("dup.stg0");
    chk("dup.plan", 64'(fwd_data[DW +: DW]), 64'h2);
    tick();

    // load-use hazard and load data forwarding
    applyStimulus(1, 7, 32'hDEAD, 1, 0, 0, 0, 0, 7, 0, 32'h77);
    checkOutput("ld.ex");
    chk("ld.hazard", 64'(hazard), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h55, 0, 0, 0, 7, 0, 32'h77);
    checkOutput("ld.stg0");
    chk("ld.stg0.plan", 64'(fwd_data[DW +: DW]), 64'h55);
    tick();
    applyStimulus(0, 0, 0, 0, 32'h99, 0, 0, 0, 7, 0, 32'h77);
    checkOutput("ld.stg1");
    chk("ld.stg1.plan", 64'(fwd_data[DW +: DW]), 64'h55);
    tick();

    // register 0 never forwards
    applyStimulus(1, 0, 32'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0");
    tick();
    applyStimulus(1, 0, 32'hFF, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0.ld");
    chk("r0.ld.hazard", 64'(hazard), 64'd0);
    tick();

    // fill, hold three cycles, flush under hold
    applyStimulus(1, 1, 32'hA1, 0, 0, 0, 0, 1, 2, 32'h1, 32'h2);
    tick();
    applyStimulus(1, 2, 32'hA2, 0, 0, 0, 0, 1, 2, 32'h1, 32'h2);
    tick();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 3, 32'hB0 + c, 0, 0, 1, 0, 1, 2, 32'h1, 32'h2);
      checkOutput($sformatf("hold%0d", c));
      chk($sformatf("hold%0d.plan", c), 64'(fwd_data[0 +: DW]), 64'hA1);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 2, 32'h1, 32'h2);
    checkOutput("flush.cycle");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h1, 32'h2);
    checkOutput("flush.after");
    chk("flush.plan", 64'(fwd_sel), 64'd0);
    tick();

    // asynchronous reset mid-stream
    applyStimulus(1, 4, 32'hC4, 0, 0, 0, 0, 4, 4, 32'h4, 32'h4);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 4, 32'h4, 32'h4);
    rst_n = 1'b0;
    hist.delete();
    #1;
    checkOutput("areset");
    chk("areset.plan", 64'(fwd_sel), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // randomized traffic on a small register window
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 19) == 0, AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), $urandom, $urandom);
      checkOutput($sformatf("rand%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
